// File: rtl/arb_mux_nto1_reg_pkg.sv
// Shared constants and helpers for the arbitrated N-to-1 registered mux.
package arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Index width that never collapses to zero bits for small channel counts.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_mux_nto1_reg_if.sv
// Requester/sink bus of the arbitrated mux; slave is the mux side, master drives the requests.
interface arb_mux_nto1_reg_if
  import arb_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 32
);
  localparam int IDX_W = clog2_min1(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] i_data;
  logic [NUM_IN-1:0]       i_valid;
  logic [NUM_IN-1:0]       o_ready;
  logic [WIDTH-1:0]        o_data;
  logic                    o_valid;
  logic                    i_ready;
  logic [IDX_W-1:0]        o_grant_idx;

  modport slave (
    input  i_data, i_valid, i_ready,
    output o_ready, o_data, o_valid, o_grant_idx
  );

  modport master (
    output i_data, i_valid, i_ready,
    input  o_ready, o_data, o_valid, o_grant_idx
  );

endinterface

// File: rtl/arb_mux_nto1_reg_pick.sv
// Combinational winner picker: rotates the request vector so the search starts after the
// pointer (round-robin) or at index 0 (fixed), then takes the lowest set bit.
module arb_pick #(
  parameter int NUM_IN = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_IN-1:0] i_req,
  input  logic [IDX_W-1:0]  i_ptr,
  input  logic              i_mode,
  output logic [IDX_W-1:0]  o_win,
  output logic              o_any
);

  logic [IDX_W:0]    start;
  logic [IDX_W:0]    off;
  logic [IDX_W:0]    sum;
  logic [NUM_IN-1:0] rot;
  logic              found;

  always_comb begin
    start = '0;
    if (i_mode && (i_ptr != IDX_W'(NUM_IN - 1)))
      start = {1'b0, i_ptr} + (IDX_W + 1)'(1);

    // Doubled vector makes the shifted window wrap without a modulo on every bit.
    rot = NUM_IN'({i_req, i_req} >> start);

    off   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (!found && rot[k]) begin
        off   = (IDX_W + 1)'(k);
        found = 1'b1;
      end
    end

    sum = start + off;
    if (sum >= (IDX_W + 1)'(NUM_IN))
      sum = sum - (IDX_W + 1)'(NUM_IN);

    o_win = IDX_W'(sum);
    o_any = |i_req;
  end

endmodule

// File: rtl/arb_mux_nto1_reg.sv
// N-input arbitrated mux with valid/ready handshake and a one-deep output register
// that can drain and reload in the same cycle.
module arb_mux_nto1_reg
  import arb_pkg::*;
#(
  parameter int NUM_IN   = 4,
  parameter int WIDTH    = 32,
  parameter int ARB_MODE = 1
) (
  input logic              i_clk,
  input logic              i_reset,
  arb_mux_nto1_reg_if.slave bus
);

  localparam int IDX_W = clog2_min1(NUM_IN);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  win;
  logic [IDX_W-1:0]  grant;
  logic [WIDTH-1:0]  data;
  logic [NUM_IN-1:0] ready;
  logic              any;
  logic              load_en;
  logic              take;

  arb_pick #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_pick (
    .i_req  (bus.i_valid),
    .i_ptr  (ptr),
    .i_mode (ARB_MODE == ARB_RR),
    .o_win  (win),
    .o_any  (any)
  );

  assign load_en = (state == EMPTY) | bus.i_ready;
  // The winner always has its valid set, so granting it completes the handshake.
  assign take    = load_en & any & ~i_reset;

  always_comb begin
    ready = '0;
    if (take)
      ready[win] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    if (take)
      state_nxt = FULL;
    else if (bus.i_ready)
      state_nxt = EMPTY;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      state <= EMPTY;
    else
      state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      data  <= '0;
      grant <= '0;
    end else if (take) begin
      data  <= bus.i_data[win*WIDTH +: WIDTH];
      grant <= win;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      ptr <= IDX_W'(NUM_IN - 1);
    else if (take && (ARB_MODE == ARB_RR))
      ptr <= win;
  end

  assign bus.o_ready     = ready;
  assign bus.o_data      = data;
  assign bus.o_valid     = (state == FULL);
  assign bus.o_grant_idx = grant;

endmodule
